// File: rtl/sine_cordic_seq.sv
// Sequential sine unit: +/-pi range reduction followed by iterative CORDIC rotation.
// Optional cos_y output is enabled by defining COS_OUT_EN.
module sine_cordic_seq #(
    parameter int INT_BITS   = 4,
    parameter int DEC_BITS   = 8,
    parameter int ITERATIONS = 12,
    parameter int GUARD_BITS = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic signed [INT_BITS+DEC_BITS:0]  x,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic signed [DEC_BITS+1:0]         y,
    output logic                               out_valid
`ifdef COS_OUT_EN
   ,output logic signed [DEC_BITS+1:0]         cos_y
`endif
);
    localparam int XW = INT_BITS + DEC_BITS + 1;
    localparam int W  = DEC_BITS + GUARD_BITS + INT_BITS + 3;
    localparam int FB = DEC_BITS + GUARD_BITS;
    localparam int YW = DEC_BITS + 2;
    localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REDUCE = 2'd1;
    localparam logic [1:0] ROTATE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    function automatic logic signed [W-1:0] q_const(input real r);
        return W'($rtoi(r * (2.0 ** FB) + 0.5));
    endfunction

    function automatic real atan_r(input int n);
        case (n)
            0:       return 0.7853981633974483;
            1:       return 0.4636476090008061;
            2:       return 0.24497866312686414;
            3:       return 0.12435499454676144;
            4:       return 0.06241880999595735;
            5:       return 0.031239833430268277;
            6:       return 0.015623728620476831;
            7:       return 0.007812341060101111;
            8:       return 0.0039062301319669718;
            9:       return 0.0019531225164788188;
            10:      return 0.0009765621895593195;
            11:      return 0.0004882812111948983;
            12:      return 0.00024414062014936177;
            13:      return 0.00012207031189367021;
            14:      return 0.00006103515617420877;
            15:      return 0.000030517578115526096;
            default: return 0.0;
        endcase
    endfunction

    localparam logic signed [W-1:0] PI       = q_const(3.141592653589793);
    localparam logic signed [W-1:0] HALF_PI  = q_const(1.5707963267948966);
    localparam logic signed [W-1:0] NHALF_PI = -HALF_PI;
    localparam logic signed [W-1:0] K_GAIN   = q_const(0.6072529);
    localparam logic signed [W-1:0] RND_HALF = W'(1) <<< (GUARD_BITS - 1);
    localparam logic signed [W-1:0] ONE      = W'(1) <<< DEC_BITS;
    localparam logic signed [W-1:0] NONE     = -ONE;
    localparam logic [IW-1:0]       LAST_IT  = IW'(ITERATIONS - 1);

    logic signed [W-1:0] atan_tab [ITERATIONS];
    for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
        localparam logic signed [W-1:0] A = q_const(atan_r(g));
        assign atan_tab[g] = A;
    end

    // Round half up, apply reduction sign, clamp to +/-1.0.
    function automatic logic signed [YW-1:0] to_out(input logic signed [W-1:0] v, input logic n);
        logic signed [W-1:0] r;
        r = (v + RND_HALF) >>> GUARD_BITS;
        if (n) r = -r;
        if (r > ONE) r = ONE;
        else if (r < NONE) r = NONE;
        return r[YW-1:0];
    endfunction

    logic [1:0]          state_q, state_d;
    logic signed [W-1:0] angle_q, angle_d;
    logic signed [W-1:0] cx_q, cx_d, cy_q, cy_d, z_q, z_d;
    logic [IW-1:0]       i_q, i_d;
    logic                neg_q, neg_d;
    logic signed [YW-1:0] y_q, y_d;
    logic                ov_q, ov_d;
`ifdef COS_OUT_EN
    logic signed [YW-1:0] cos_q, cos_d;
`endif

    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        z_d     = z_q;
        i_d     = i_q;
        neg_d   = neg_q;
        y_d     = y_q;
        ov_d    = 1'b0;
`ifdef COS_OUT_EN
        cos_d   = cos_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                // Angle register holds x already scaled to the internal precision.
                angle_d = {{(W-XW-GUARD_BITS){x[XW-1]}}, x, {GUARD_BITS{1'b0}}};
                neg_d   = 1'b0;
                state_d = REDUCE;
            end
            REDUCE: begin
                if (angle_q > HALF_PI) begin
                    angle_d = angle_q - PI;
                    neg_d   = ~neg_q;
                end else if (angle_q < NHALF_PI) begin
                    angle_d = angle_q + PI;
                    neg_d   = ~neg_q;
                end else begin
                    cx_d    = K_GAIN;
                    cy_d    = '0;
                    z_d     = angle_q;
                    i_d     = '0;
                    state_d = ROTATE;
                end
            end
            ROTATE: begin
                if (!z_q[W-1]) begin
                    cx_d = cx_q - (cy_q >>> i_q);
                    cy_d = cy_q + (cx_q >>> i_q);
                    z_d  = z_q - atan_tab[i_q];
                end else begin
                    cx_d = cx_q + (cy_q >>> i_q);
                    cy_d = cy_q - (cx_q >>> i_q);
                    z_d  = z_q + atan_tab[i_q];
                end
                i_d = i_q + IW'(1);
                if (i_q == LAST_IT) state_d = DONE;
            end
            default: begin
                y_d     = to_out(cy_q, neg_q);
`ifdef COS_OUT_EN
                cos_d   = to_out(cx_q, neg_q);
`endif
                ov_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            angle_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            z_q     <= '0;
            i_q     <= '0;
            neg_q   <= 1'b0;
            y_q     <= '0;
            ov_q    <= 1'b0;
`ifdef COS_OUT_EN
            cos_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            z_q     <= z_d;
            i_q     <= i_d;
            neg_q   <= neg_d;
            y_q     <= y_d;
            ov_q    <= ov_d;
`ifdef COS_OUT_EN
            cos_q   <= cos_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign y         = y_q;
    assign out_valid = ov_q;
`ifdef COS_OUT_EN
    assign cos_y     = cos_q;
`endif

endmodule
